// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer entry controller.
//   state_e           : controller FSM states
//   KEY_START/CANCEL  : keypad command codes (0-9 are digits, 12-15 ignored)
//   DIGIT_W           : width of one BCD digit
//   QUICK_START_VALUE : buffer contents for a one-touch 00:30 start
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOAD,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam int          DIGIT_W           = 4;
    localparam logic [3:0]  KEY_START         = 4'd10;
    localparam logic [3:0]  KEY_CANCEL        = 4'd11;
    localparam logic [15:0] QUICK_START_VALUE = 16'h0030;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/entry_shift_buf.sv
// Keypad entry buffer: NUM_DIGITS BCD digits, shifted left as digits arrive
// (new digit enters the least significant position).
//   clk, reset : clock, async active-high reset
//   shift_en   : shift digit_in into the buffer (caller gates with !full)
//   digit_in   : BCD digit to shift in
//   clr        : clear buffer and digit count (highest priority)
//   ld_en      : parallel load ld_value, digit count cleared
//   cnt_clr    : clear only the digit count, contents kept
//   buf_o      : buffer contents, most significant digit first
//   full       : NUM_DIGITS digits have been entered since last clear
module entry_shift_buf
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          shift_en,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          clr,
    input  logic                          ld_en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] ld_value,
    input  logic                          cnt_clr,
    output logic [NUM_DIGITS*DIGIT_W-1:0] buf_o,
    output logic                          full
);

    localparam int BUF_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign full  = (cnt_q == CNT_W'(NUM_DIGITS));
    assign buf_o = buf_q;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clr) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (ld_en) begin
            buf_d = ld_value;
            cnt_d = '0;
        end else if (cnt_clr) begin
            cnt_d = '0;
        end else if (shift_en) begin
            buf_d = {buf_q[BUF_W-DIGIT_W-1:0], digit_in};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_entry_ctrl.sv
// Microwave timer entry controller: collects MM:SS keypad digits, validates
// them, loads the BCD down-counter chain and gates its stop input with the
// 1 Hz tick until the chain reports zero. Handles cancel, door pause and done.
// Optional feature macro QUICK_START_EN: START in IDLE (door closed) loads
// 00:30 and starts immediately; without it START in IDLE is rejected.
//   clk, reset     : clock, async active-high reset
//   key_valid/code : keypad strobe and code (0-9 digit, 10 START, 11 CANCEL)
//   door_open      : door level, pauses cooking and blocks START
//   tick           : 1 Hz one-cycle enable
//   timer_zero     : all counters in the chain are zero
//   bcd_load_value : {min_t, min_o, sec_t, sec_o} entry buffer
//   load           : one-cycle counter load pulse
//   stop           : counter hold, low only on a running tick cycle
//   clear_cnt      : one-cycle counter clear pulse (after CANCEL)
//   running        : magnetron enable
//   done           : completion beep, DONE_CYCLES long
//   entry_err      : one-cycle pulse on a rejected START
module timer_entry_ctrl
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DONE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    input  logic                          door_open,
    input  logic                          tick,
    input  logic                          timer_zero,
    output logic [NUM_DIGITS*DIGIT_W-1:0] bcd_load_value,
    output logic                          load,
    output logic                          stop,
    output logic                          clear_cnt,
    output logic                          running,
    output logic                          done,
    output logic                          entry_err
);

    localparam int BUF_W = NUM_DIGITS * DIGIT_W;
    localparam int DC_W  = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [DC_W-1:0]   done_cnt_q, done_cnt_d;
    logic              in_run_q, in_run_d;
    logic              entry_err_q, entry_err_d;
    logic              clear_cnt_q, clear_cnt_d;

    logic              key_digit, key_start, key_cancel;
    logic              shift_en, buf_clr, buf_ld, cnt_clr, buf_full;
    logic              entry_invalid, run_active;
    logic [BUF_W-1:0]  buf_val;

    assign key_digit  = key_valid && is_digit(key_code);
    assign key_start  = key_valid && (key_code == KEY_START);
    assign key_cancel = key_valid && (key_code == KEY_CANCEL);

    // Seconds tens digit above 5 or an all-zero time cannot be cooked.
    assign entry_invalid = (buf_val[2*DIGIT_W-1:DIGIT_W] > 4'd5) || (buf_val == '0);

    entry_shift_buf #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .digit_in (key_code),
        .clr      (buf_clr),
        .ld_en    (buf_ld),
        .ld_value (BUF_W'(QUICK_START_VALUE)),
        .cnt_clr  (cnt_clr),
        .buf_o    (buf_val),
        .full     (buf_full)
    );

    always_comb begin
        state_d     = state_q;
        done_cnt_d  = done_cnt_q;
        entry_err_d = 1'b0;
        clear_cnt_d = 1'b0;
        shift_en    = 1'b0;
        buf_clr     = 1'b0;
        buf_ld      = 1'b0;
        cnt_clr     = 1'b0;
        run_active  = 1'b0;

        // LOAD is a single committed cycle; every key, CANCEL included, is
        // dropped there so the counters never see load and clear together.
        if (key_cancel && state_q != ST_LOAD) begin
            clear_cnt_d = 1'b1;
            buf_clr     = 1'b1;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (key_digit) begin
                        shift_en = !buf_full;
                        state_d  = ST_ENTRY;
                    end else if (key_start) begin
                        if (door_open) begin
                            entry_err_d = 1'b1;
                        end else if (state_q == ST_IDLE) begin
`ifdef QUICK_START_EN
                            buf_ld  = 1'b1;
                            state_d = ST_LOAD;
`else
                            entry_err_d = 1'b1;
`endif
                        end else if (entry_invalid) begin
                            entry_err_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt_clr = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Door beats tick; zero is trusted only after the chain
                    // has had one RUN cycle to settle.
                    if (door_open) begin
                        state_d = ST_PAUSE;
                    end else if (in_run_q && timer_zero) begin
                        state_d    = ST_DONE;
                        done_cnt_d = '0;
                    end else begin
                        run_active = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (key_start) begin
                        if (door_open) entry_err_d = 1'b1;
                        else           state_d     = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (done_cnt_q == DC_W'(DONE_CYCLES - 1)) begin
                        state_d    = ST_IDLE;
                        buf_clr    = 1'b1;
                        done_cnt_d = '0;
                    end else begin
                        done_cnt_d = done_cnt_q + DC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign in_run_d = (state_q == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            done_cnt_q  <= '0;
            in_run_q    <= 1'b0;
            entry_err_q <= 1'b0;
            clear_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_cnt_q  <= done_cnt_d;
            in_run_q    <= in_run_d;
            entry_err_q <= entry_err_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    assign bcd_load_value = buf_val;
    assign load           = (state_q == ST_LOAD);
    assign running        = run_active;
    assign stop           = !(run_active && tick);
    assign done           = (state_q == ST_DONE);
    assign entry_err      = entry_err_q;
    assign clear_cnt      = clear_cnt_q;

endmodule

// File: tb/tb_timer_entry_ctrl.sv
module tb_timer_entry_ctrl;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        door_open = 1'b0;
    logic        tick = 1'b0;
    logic        timer_zero = 1'b0;
    logic [15:0] bcd_load_value;
    logic        load, stop, clear_cnt, running, done, entry_err;

    timer_entry_ctrl #(.NUM_DIGITS(4), .DONE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .door_open(door_open), .tick(tick), .timer_zero(timer_zero),
        .bcd_load_value(bcd_load_value), .load(load), .stop(stop),
        .clear_cnt(clear_cnt), .running(running), .done(done), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    localparam int EV_LOAD = 0, EV_ERR = 1, EV_CLR = 2, EV_STOP = 3, EV_DONE = 4;
    typedef struct { int kind; logic [15:0] val; } ev_t;
    ev_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int done_len = 0;

    function automatic void push(input int kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    task automatic chk_ev(input int kind, input logic [15:0] val, input string name);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event kind=%0d val=%h, none expected", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                bad++;
                $display("FAIL %s: got kind=%0d val=%h, expected kind=%0d val=%h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (load)      chk_ev(EV_LOAD, bcd_load_value, "load");
            if (entry_err) chk_ev(EV_ERR, 16'h0, "entry_err");
            if (clear_cnt) chk_ev(EV_CLR, 16'h0, "clear_cnt");
            if (!stop)     chk_ev(EV_STOP, 16'h0, "stop_low");
            if (done) done_len++;
            else if (done_len != 0) begin
                chk_ev(EV_DONE, 16'(done_len), "done_len");
                done_len = 0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        cyc();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    // Nine quiet cycles then one tick cycle; checks running/stop mid-tick.
    task automatic do_tick(input logic expect_dec);
        cyc(9);
        if (expect_dec) push(EV_STOP, 16'h0);
        tick = 1'b1;
        @(negedge clk);
        check("tick_running", {15'd0, running}, {15'd0, expect_dec});
        check("tick_stop", {15'd0, stop}, {15'd0, !expect_dec});
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_bcd", bcd_load_value, 16'h0000);
        check("rst_outs", {10'd0, load, stop, clear_cnt, running, done, entry_err}, 16'b000000_0000_010000);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc();

        // START from IDLE
`ifdef QUICK_START_EN
        push(EV_LOAD, 16'h0030);
        key(KEY_START);
        cyc(3);
        push(EV_CLR, 16'h0);
        key(KEY_CANCEL);
`else
        push(EV_ERR, 16'h0);
        key(KEY_START);
`endif
        cyc(2);

        // 1,3,0 START; 5 ticks; timer_zero; done for 8 cycles
        key(4'd1); key(4'd3); key(4'd0);
        check("entry_130", bcd_load_value, 16'h0130);
        push(EV_LOAD, 16'h0130);
        key(KEY_START);
        for (int i = 0; i < 5; i++) do_tick(1'b1);
        push(EV_DONE, 16'd8);
        timer_zero = 1'b1;
        #1 check("zero_running", {15'd0, running}, 16'h0);
        cyc(12);
        timer_zero = 1'b0;
        cyc(2);
        check("after_done_bcd", bcd_load_value, 16'h0000);

        // 0,0,9,0 START -> rejected, stays in ENTRY
        key(4'd0); key(4'd0); key(4'd9); key(4'd0);
        push(EV_ERR, 16'h0);
        key(KEY_START);
        cyc(2);
        check("reject_keeps_buf", bcd_load_value, 16'h0090);
        push(EV_CLR, 16'h0);
        key(KEY_CANCEL);
        cyc();
        check("cancel_clears", bcd_load_value, 16'h0000);

        // Fifth digit ignored
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("full_buf", bcd_load_value, 16'h1234);
        push(EV_CLR, 16'h0);
        key(KEY_CANCEL);

        // START with door open is rejected
        key(4'd5);
        door_open = 1'b1;
        push(EV_ERR, 16'h0);
        key(KEY_START);
        door_open = 1'b0;
        cyc();
        check("door_start_buf", bcd_load_value, 16'h0005);
        push(EV_CLR, 16'h0);
        key(KEY_CANCEL);

        // All-zero entry is rejected
        key(4'd0);
        push(EV_ERR, 16'h0);
        key(KEY_START);
        cyc();
        push(EV_CLR, 16'h0);
        key(KEY_CANCEL);

        // sec_t = 5 boundary is accepted
        key(4'd5); key(4'd9);
        push(EV_LOAD, 16'h0059);
        key(KEY_START);
        cyc(3);
        push(EV_CLR, 16'h0);
        key(KEY_CANCEL);
        cyc();

        // Door pause for 3 ticks, then resume with START
        key(4'd2); key(4'd0); key(4'd0);
        push(EV_LOAD, 16'h0200);
        key(KEY_START);
        do_tick(1'b1);
        door_open = 1'b1;
        for (int i = 0; i < 3; i++) do_tick(1'b0);
        door_open = 1'b0;
        cyc();
        key(KEY_START);
        cyc();
        check("resume_running", {15'd0, running}, 16'h0001);
        do_tick(1'b1);

        // CANCEL mid-RUN
        push(EV_CLR, 16'h0);
        key(KEY_CANCEL);
        cyc();
        check("cancel_running", {15'd0, running}, 16'h0);
        check("cancel_bcd", bcd_load_value, 16'h0000);
        do_tick(1'b0);

        // Asynchronous reset mid-RUN
        key(4'd1); key(4'd0);
        push(EV_LOAD, 16'h0010);
        key(KEY_START);
        cyc(3);
        check("pre_rst_running", {15'd0, running}, 16'h0001);
        #1 reset = 1'b1;
        #1;
        check("async_rst_bcd", bcd_load_value, 16'h0000);
        check("async_rst_outs", {10'd0, load, stop, clear_cnt, running, done, entry_err}, 16'b000000_0000_010000);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(3);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d events left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
